lb_uart_bridge: RTL and testbench
=================================

# lb_uart_bridge

Host-command front end for the local bus. It parses a byte stream from the UART receiver into local-bus read/write transactions (8-bit command, 24-bit address, 32-bit data) and issues them to the configuration/DSP register space. Read data is returned as bytes to the UART transmitter. It sits between the UART byte link and the local-bus consumers in the configuration block, and is the only local-bus master in the design.

## Interface
Parameters:
- RD_TIMEOUT, 1024: cycles to wait for lb_rvalid after lb_rd before a timeout response.
- IDLE_TIMEOUT, 65535: cycles without rx_valid, mid-frame, before the parser drops the partial frame.
- TIMEOUT_WORD, 32'hDEADBEEF: data returned on a read timeout.

Ports:
- clk  in  1  sole clock; all logic is on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data is valid; held until accepted.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid&tx_ready.
- lb_cmd  out  8  command byte of the current transaction.
- lb_addr  out  24  address.
- lb_wdata  out  32  write data.
- lb_wr  out  1  one-cycle write strobe.
- lb_rd  out  1  one-cycle read strobe.
- lb_rdata  in  32  read data, sampled when lb_rvalid=1.
- lb_rvalid  in  1  read-data valid strobe.
- err_cnt  out  8  saturating count of frame errors (timeouts, overruns).

## Operation
- Frame: byte 0 is the command. cmd[0]=1 marks a read and cmd[0]=0 a write. Bytes 1-3 are the address, MSB first. For a write, bytes 4-7 are the data, MSB first. A read frame is 4 bytes and a write frame is 8 bytes.
- States and transitions:
  - IDLE: the first rx_valid captures lb_cmd and moves to ADDR.
  - ADDR: collects 3 bytes. For a read it then moves to RD; for a write it moves to DATA.
  - DATA: collects 4 bytes, then moves to WR.
  - WR: pulses lb_wr for one cycle, then moves to IDLE.
  - RD: pulses lb_rd for one cycle, then moves to RWAIT.
  - RWAIT: captures lb_rdata on lb_rvalid and moves to TX. After RD_TIMEOUT cycles without lb_rvalid, it loads TIMEOUT_WORD, increments err_cnt and moves to TX.
  - TX: sends 4 bytes, MSB first, each held on tx_data/tx_valid until tx_ready. After the 4th byte is accepted it moves to IDLE.
- Byte shifting: address and data are shift registers of the form {reg[n-9:0], rx_data}.
- Output stability:
  - lb_cmd, lb_addr and lb_wdata are stable from the lb_wr/lb_rd strobe until the next frame's first byte.
  - lb_wdata is not modified by read frames.
- Idle timeout: in ADDR or DATA, a counter reloads on every rx_valid. When it reaches IDLE_TIMEOUT, the parser returns to IDLE, discards the partial frame and increments err_cnt.
- Overrun: rx_valid during WR, RD, RWAIT or TX drops the byte and increments err_cnt. The current transaction is not disturbed.
- lb_rvalid outside RWAIT is ignored.
- err_cnt saturates at 255 and is cleared only by reset.
- Simultaneous events: if a timeout and an error occur in the same cycle, err_cnt increments once.

## Timing
- Reset values (async on rstn low):
  - State IDLE.
  - tx_data=0, tx_valid=0.
  - lb_cmd=0, lb_addr=0, lb_wdata=0.
  - lb_wr=0, lb_rd=0.
  - err_cnt=0.
  - All counters 0.
- Reset mid-frame or mid-read aborts immediately. No strobe is emitted after release.
- Write latency: lb_wr is high exactly in the cycle after the clock edge that samples the 8th byte.
- Read latency:
  - lb_rd is high exactly in the cycle after the 4th byte is sampled.
  - tx_valid rises in the cycle after the edge where lb_rvalid is sampled high, or after the timeout expires.
  - Timeout expires RD_TIMEOUT cycles after lb_rd.
- Transmit: tx_data advances to the next byte in the cycle after a tx_valid&tx_ready handshake.
- Back-to-back: a new command byte is accepted in the cycle immediately after WR, or after the final TX handshake.
- All outputs are registered.

## Test plan
- Write: send bytes 02 12 34 56 DE AD BE EF. Require one lb_wr pulse with lb_cmd=02, lb_addr=123456, lb_wdata=DEADBEEF, and no lb_rd.
- Read: send 01 00 00 10. The bench returns lb_rvalid with lb_rdata=CAFEF00D 3 cycles after lb_rd. Require tx bytes CA FE F0 0D in order. Drop tx_ready for 5 cycles mid-word and require no byte lost or repeated.
- Read timeout: use RD_TIMEOUT=16 and send 01 00 00 20 with no lb_rvalid. Require tx bytes DE AD BE EF, err_cnt=1, and tx_valid rising 17 cycles after lb_rd.
- Idle timeout: use IDLE_TIMEOUT=100. Send 02 00 01, wait 150 cycles, then send a full write frame 02 00 00 04 00 00 00 01. Require exactly one lb_wr with addr=000004, data=00000001, and err_cnt=1.
- Overrun: during RWAIT, inject byte 55. Require that it is dropped, err_cnt increments, and the read completes normally. Also inject 300 overruns and require err_cnt=FF.
- Reset mid-frame: assert rstn=0 after 5 bytes of a write. Require no lb_wr, all outputs at reset values, and the next full frame executes correctly.

Source files
------------

// File: rtl/lb_uart_bridge.sv
// UART byte-stream to local-bus bridge: parses cmd/addr/data frames, issues
// lb_wr/lb_rd strobes and returns read data (or a timeout word) as four bytes.
`timescale 1ns/1ps
module lb_uart_bridge #(
  parameter int          RD_TIMEOUT   = 1024,
  parameter int          IDLE_TIMEOUT = 65535,
  parameter logic [31:0] TIMEOUT_WORD = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  lb_cmd,
  output logic [23:0] lb_addr,
  output logic [31:0] lb_wdata,
  output logic        lb_wr,
  output logic        lb_rd,
  input  logic [31:0] lb_rdata,
  input  logic        lb_rvalid,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WR, RD, RWAIT, TX} state_t;

  // One counter serves both the mid-frame idle timeout and the read-wait timeout.
  localparam int CNT_MAX = (RD_TIMEOUT > IDLE_TIMEOUT) ? RD_TIMEOUT : IDLE_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(RD_TIMEOUT - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    bcnt;
  logic [31:0]   rword;
  logic          rd_expire;
  logic          idle_expire;
  logic          overrun;
  logic          err_event;

  // Error sources are OR-ed so coincident events bump err_cnt only once.
  always_comb begin
    rd_expire   = (state == RWAIT) && !lb_rvalid && (cnt == RD_LAST);
    idle_expire = ((state == ADDR) || (state == DATA)) && !rx_valid && (cnt == IDLE_LAST);
    overrun     = rx_valid && (state inside {WR, RD, RWAIT, TX});
    err_event   = rd_expire | idle_expire | overrun;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      bcnt     <= '0;
      rword    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      lb_cmd   <= '0;
      lb_addr  <= '0;
      lb_wdata <= '0;
      lb_wr    <= 1'b0;
      lb_rd    <= 1'b0;
      err_cnt  <= '0;
    end else begin
      lb_wr <= 1'b0;
      lb_rd <= 1'b0;
      if (err_event && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            lb_cmd <= rx_data;
            bcnt   <= '0;
            cnt    <= '0;
            state  <= ADDR;
          end
        end
        ADDR: begin
          if (rx_valid) begin
            cnt     <= '0;
            lb_addr <= {lb_addr[15:0], rx_data};
            if (bcnt == 2'd2) begin
              bcnt <= '0;
              if (lb_cmd[0]) begin
                lb_rd <= 1'b1;
                state <= RD;
              end else begin
                state <= DATA;
              end
            end else begin
              bcnt <= bcnt + 2'd1;
            end
          end else if (idle_expire) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (rx_valid) begin
            cnt      <= '0;
            lb_wdata <= {lb_wdata[23:0], rx_data};
            if (bcnt == 2'd3) begin
              bcnt  <= '0;
              lb_wr <= 1'b1;
              state <= WR;
            end else begin
              bcnt <= bcnt + 2'd1;
            end
          end else if (idle_expire) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WR: state <= IDLE;
        RD: begin
          cnt   <= '0;
          state <= RWAIT;
        end
        RWAIT: begin
          if (lb_rvalid) begin
            rword    <= lb_rdata;
            tx_data  <= lb_rdata[31:24];
            tx_valid <= 1'b1;
            bcnt     <= '0;
            state    <= TX;
          end else if (rd_expire) begin
            rword    <= TIMEOUT_WORD;
            tx_data  <= TIMEOUT_WORD[31:24];
            tx_valid <= 1'b1;
            bcnt     <= '0;
            state    <= TX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // rword keeps the byte on tx_data in its top lane; shift after each handshake.
        TX: begin
          if (tx_ready) begin
            if (bcnt == 2'd3) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end else begin
              bcnt    <= bcnt + 2'd1;
              rword   <= {rword[23:0], 8'h00};
              tx_data <= rword[23:16];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lb_uart_bridge.sv
// Directed bench for lb_uart_bridge: write, read with backpressure, timeouts,
// overruns with saturation, and reset in the middle of a frame.
`timescale 1ns/1ps
module tb_lb_uart_bridge;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  lb_cmd;
  logic [23:0] lb_addr;
  logic [31:0] lb_wdata;
  logic        lb_wr;
  logic        lb_rd;
  logic [31:0] lb_rdata = '0;
  logic        lb_rvalid = 1'b0;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;

  lb_uart_bridge #(
    .RD_TIMEOUT  (16),
    .IDLE_TIMEOUT(100),
    .TIMEOUT_WORD(32'hDEADBEEF)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .lb_cmd   (lb_cmd),
    .lb_addr  (lb_addr),
    .lb_wdata (lb_wdata),
    .lb_wr    (lb_wr),
    .lb_rd    (lb_rd),
    .lb_rdata (lb_rdata),
    .lb_rvalid(lb_rvalid),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor samples on the falling edge; stimulus only changes just after rising edges.
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cyc = -1;
  int          rd_cyc = -1;
  int          txv_rise_cyc = -1;
  logic        txv_prev = 1'b0;
  logic [7:0]  wr_cmd;
  logic [23:0] wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  tx_q[$];

  always @(negedge clk) begin
    if (lb_wr === 1'b1) begin
      wr_cnt  = wr_cnt + 1;
      wr_cyc  = cyc;
      wr_cmd  = lb_cmd;
      wr_addr = lb_addr;
      wr_data = lb_wdata;
    end
    if (lb_rd === 1'b1) begin
      rd_cnt = rd_cnt + 1;
      rd_cyc = cyc;
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_q.push_back(tx_data);
    if (tx_valid === 1'b1 && txv_prev !== 1'b1) txv_rise_cyc = cyc;
    txv_prev = tx_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask

  task automatic do_reset();
    rx_valid  = 1'b0;
    lb_rvalid = 1'b0;
    rstn      = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && tx_q.size() < n; i++) tick();
  endtask

  function automatic logic [7:0] txq_at(input int idx);
    if (idx < tx_q.size()) return tx_q[idx];
    return 8'hxx;
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    checks++;
    if ({tx_data, tx_valid, lb_cmd, lb_addr, lb_wdata, lb_wr, lb_rd, err_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: got tx=%h/%b cmd=%h addr=%h wdata=%h wr=%b rd=%b err=%h, want all zero",
               tx_data, tx_valid, lb_cmd, lb_addr, lb_wdata, lb_wr, lb_rd, err_cnt);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_write();
    int wr0, rd0, last;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    send_word(32'hDEADBEEF);
    last = cyc;
    tick(); tick(); tick();
    checks++;
    if (wr_cnt - wr0 != 1) begin errors++; $display("[TB] FAIL write_pulses: got %0d want 1", wr_cnt - wr0); end
    checks++;
    if ({wr_cmd, wr_addr, wr_data} !== {8'h02, 24'h123456, 32'hDEADBEEF}) begin
      errors++;
      $display("[TB] FAIL write_fields: got cmd=%h addr=%h data=%h want 02/123456/deadbeef", wr_cmd, wr_addr, wr_data);
    end
    checks++;
    if (wr_cyc != last) begin errors++; $display("[TB] FAIL write_latency: lb_wr in cycle %0d want %0d", wr_cyc, last); end
    checks++;
    if (rd_cnt != rd0) begin errors++; $display("[TB] FAIL write_no_read: got %0d lb_rd pulses want 0", rd_cnt - rd0); end
  endtask

  task automatic test_read();
    int base, rd0, last;
    logic [31:0] exp_w;
    exp_w = 32'hCAFEF00D;
    base  = tx_q.size();
    rd0   = rd_cnt;
    tx_ready = 1'b1;
    send_word(32'h01000010);
    last = cyc;
    tick(); tick(); tick();
    lb_rdata  = exp_w;
    lb_rvalid = 1'b1;
    tick();
    lb_rvalid = 1'b0;
    checks++;
    if (rd_cnt - rd0 != 1 || rd_cyc != last) begin
      errors++;
      $display("[TB] FAIL read_strobe: got %0d pulses at cycle %0d want 1 at %0d", rd_cnt - rd0, rd_cyc, last);
    end
    wait_tx(base + 2, 20);
    tx_ready = 1'b0;
    repeat (5) tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hF0 || tx_q.size() != base + 2) begin
      errors++;
      $display("[TB] FAIL read_stall: got valid=%b data=%h sent=%0d want 1/f0/2", tx_valid, tx_data, tx_q.size() - base);
    end
    tx_ready = 1'b1;
    wait_tx(base + 4, 20);
    tick(); tick(); tick();
    checks++;
    if (tx_q.size() != base + 4 || tx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_count: got %0d bytes valid=%b want 4 bytes valid=0", tx_q.size() - base, tx_valid);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (txq_at(base + i) !== exp_w[31-8*i -: 8]) begin
        errors++;
        $display("[TB] FAIL read_byte%0d: got %h want %h", i, txq_at(base + i), exp_w[31-8*i -: 8]);
      end
    end
    checks++;
    if (lb_wdata !== 32'hDEADBEEF || lb_addr !== 24'h000010 || lb_cmd !== 8'h01) begin
      errors++;
      $display("[TB] FAIL read_regs: got cmd=%h addr=%h wdata=%h want 01/000010/deadbeef", lb_cmd, lb_addr, lb_wdata);
    end
  endtask

  task automatic test_back_to_back();
    int base, wr0, rd0, last;
    base = tx_q.size();
    wr0  = wr_cnt;
    rd0  = rd_cnt;
    send_word(32'h04AABBCC);
    send_word(32'h11223344);
    tick();
    send_word(32'h05000050);
    last = cyc;
    tick(); tick(); tick();
    checks++;
    if (wr_cnt - wr0 != 1 || wr_addr !== 24'hAABBCC || wr_data !== 32'h11223344) begin
      errors++;
      $display("[TB] FAIL b2b_write: got %0d pulses addr=%h data=%h want 1/aabbcc/11223344", wr_cnt - wr0, wr_addr, wr_data);
    end
    checks++;
    if (rd_cnt - rd0 != 1 || rd_cyc != last) begin
      errors++;
      $display("[TB] FAIL b2b_read: got %0d pulses at %0d want 1 at %0d", rd_cnt - rd0, rd_cyc, last);
    end
    checks++;
    if (lb_cmd !== 8'h05 || lb_addr !== 24'h000050 || lb_wdata !== 32'h11223344 || err_cnt !== 8'h00) begin
      errors++;
      $display("[TB] FAIL b2b_regs: got cmd=%h addr=%h wdata=%h err=%h want 05/000050/11223344/00",
               lb_cmd, lb_addr, lb_wdata, err_cnt);
    end
    lb_rdata  = 32'hA1B2C3D4;
    lb_rvalid = 1'b1;
    tick();
    lb_rvalid = 1'b0;
    wait_tx(base + 4, 20);
    checks++;
    if ({txq_at(base), txq_at(base + 1), txq_at(base + 2), txq_at(base + 3)} !== 32'hA1B2C3D4) begin
      errors++;
      $display("[TB] FAIL b2b_bytes: got %h%h%h%h want a1b2c3d4", txq_at(base), txq_at(base + 1), txq_at(base + 2), txq_at(base + 3));
    end
    tick(); tick();
  endtask

  task automatic test_rd_timeout();
    int base;
    logic [31:0] exp_w;
    exp_w = 32'hDEADBEEF;
    do_reset();
    base = tx_q.size();
    tx_ready = 1'b1;
    send_word(32'h01000020);
    wait_tx(base + 4, 60);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (txq_at(base + i) !== exp_w[31-8*i -: 8]) begin
        errors++;
        $display("[TB] FAIL timeout_byte%0d: got %h want %h", i, txq_at(base + i), exp_w[31-8*i -: 8]);
      end
    end
    checks++;
    if (err_cnt !== 8'd1) begin errors++; $display("[TB] FAIL timeout_err: got %0d want 1", err_cnt); end
    checks++;
    if (txv_rise_cyc - rd_cyc != 17) begin
      errors++;
      $display("[TB] FAIL timeout_latency: tx_valid rose %0d cycles after lb_rd want 17", txv_rise_cyc - rd_cyc);
    end
  endtask

  task automatic test_idle_timeout();
    int wr0;
    do_reset();
    wr0 = wr_cnt;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    repeat (150) tick();
    send_word(32'h02000004);
    send_word(32'h00000001);
    tick(); tick(); tick();
    checks++;
    if (wr_cnt - wr0 != 1 || wr_addr !== 24'h000004 || wr_data !== 32'h00000001) begin
      errors++;
      $display("[TB] FAIL idle_write: got %0d pulses addr=%h data=%h want 1/000004/00000001", wr_cnt - wr0, wr_addr, wr_data);
    end
    checks++;
    if (err_cnt !== 8'd1) begin errors++; $display("[TB] FAIL idle_err: got %0d want 1", err_cnt); end
  endtask

  task automatic test_overrun();
    int base, wr0;
    logic [31:0] exp_w;
    exp_w = 32'h12345678;
    do_reset();
    base = tx_q.size();
    wr0  = wr_cnt;
    tx_ready = 1'b1;
    send_word(32'h01000030);
    tick();
    send_byte(8'h55);
    lb_rdata  = exp_w;
    lb_rvalid = 1'b1;
    tick();
    lb_rvalid = 1'b0;
    wait_tx(base + 4, 20);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (txq_at(base + i) !== exp_w[31-8*i -: 8]) begin
        errors++;
        $display("[TB] FAIL overrun_byte%0d: got %h want %h", i, txq_at(base + i), exp_w[31-8*i -: 8]);
      end
    end
    checks++;
    if (err_cnt !== 8'd1 || lb_cmd !== 8'h01 || lb_addr !== 24'h000030 || wr_cnt != wr0) begin
      errors++;
      $display("[TB] FAIL overrun_state: got err=%0d cmd=%h addr=%h wr=%0d want 1/01/000030/0",
               err_cnt, lb_cmd, lb_addr, wr_cnt - wr0);
    end
    base = tx_q.size();
    tx_ready = 1'b0;
    send_word(32'h01000040);
    repeat (300) send_byte(8'h55);
    checks++;
    if (err_cnt !== 8'hFF) begin errors++; $display("[TB] FAIL overrun_saturate: got %h want ff", err_cnt); end
    tx_ready = 1'b1;
    wait_tx(base + 4, 20);
    tick(); tick();
    checks++;
    if (tx_q.size() != base + 4 || txq_at(base) !== 8'hDE || err_cnt !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL overrun_drain: got %0d bytes first=%h err=%h want 4/de/ff", tx_q.size() - base, txq_at(base), err_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int wr0, rd0, last;
    do_reset();
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    send_word(32'h02112233);
    send_byte(8'h44);
    rstn = 1'b0;
    #1;
    checks++;
    if ({tx_data, tx_valid, lb_cmd, lb_addr, lb_wdata, lb_wr, lb_rd, err_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL midframe_reset_values: got cmd=%h addr=%h wdata=%h wr=%b rd=%b err=%h want all zero",
               lb_cmd, lb_addr, lb_wdata, lb_wr, lb_rd, err_cnt);
    end
    tick();
    rstn = 1'b1;
    repeat (20) tick();
    checks++;
    if (wr_cnt != wr0 || rd_cnt != rd0) begin
      errors++;
      $display("[TB] FAIL midframe_no_strobe: got wr=%0d rd=%0d want 0/0", wr_cnt - wr0, rd_cnt - rd0);
    end
    send_word(32'h02000008);
    send_word(32'h12345678);
    last = cyc;
    tick(); tick();
    checks++;
    if (wr_cnt - wr0 != 1 || wr_cyc != last || wr_addr !== 24'h000008 || wr_data !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL midframe_next_write: got %0d pulses cyc=%0d addr=%h data=%h want 1/%0d/000008/12345678",
               wr_cnt - wr0, wr_cyc, wr_addr, wr_data, last);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_rd_timeout();
    test_idle_timeout();
    test_overrun();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
